vec_sca_responder: RTL
======================

Name: vec_sca_responder

Overview:
- Vector-side responder for the scalar-core accelerator interface: accepts sca_req_t requests and returns exactly one sca_resp_t per request.
- Responses return in request order.
- Legal vector instructions are forwarded to the vector decode/dispatch stage with a slot tag. Out-of-order completions from the backend are reordered in a DEPTH-entry in-order tracking table.
- Illegal (non-vector) major opcodes are answered with err=1 and never dispatched.

Parameters:
DEPTH, 4, outstanding-request table entries; power of two, >=2
TAG_BITS, $clog2(DEPTH), width of the slot tag given to the backend

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
sca_req_valid_i  in  1  request valid
sca_req_ready_o  out  1  request accepted when valid&ready
sca_req_i  in  sca_req_t  instr, rs1, rs2, instr_id
sca_resp_valid_o  out  1  response valid
sca_resp_ready_i  in  1  scalar core takes response
sca_resp_o  out  sca_resp_t  err, res, instr_id
disp_valid_o  out  1  dispatch valid (registered)
disp_ready_i  in  1  dispatch consumed
disp_instr_o  out  32  instruction word
disp_rs1_o  out  XLEN  scalar operand 1
disp_rs2_o  out  XLEN  scalar operand 2
disp_tag_o  out  TAG_BITS  table slot of this instruction
cmpl_valid_i  in  1  backend completion strobe, no backpressure
cmpl_tag_i  in  TAG_BITS  slot completed
cmpl_err_i  in  1  backend error
cmpl_res_i  in  XLEN  scalar result (e.g. vsetvl vl, vmv.x.s)
busy_o  out  1  count_q != 0 or disp_valid_o
proto_err_o  out  1  sticky: completion to invalid or already-done slot

Behaviour:
- Reset (rst_i high at clk_i edge):
  - clears all entry valid/done bits, head, tail, count_q, the dispatch register and proto_err_o.
  - All outputs are 0 the cycle after reset.
  - A reset mid-operation drops in-flight entries silently; a completion arriving in the reset cycle is ignored.
- Table:
  - Per entry: valid, done, err, res[XLEN], instr_id.
  - head/tail pointers wrap mod DEPTH; count_q ranges 0..DEPTH.
- Legality: instr[6:0] in {0x57 OP-V, 0x07 LOAD-FP, 0x27 STORE-FP} is legal; everything else is illegal.
- Request ready: sca_req_ready_o = (count_q < DEPTH) && (!disp_valid_o || disp_ready_i).
  - It uses registered count_q, so no allocation into a full table even if the head retires the same cycle.
  - The combinational path from disp_ready_i is permitted.
- Accept (valid&ready), cycle N:
  - Writes table[tail] {valid=1, instr_id}; tail++ and count++.
  - Legal request: done=0, and the dispatch register loads {instr, rs1, rs2, tag=tail}, so disp_valid_o=1 at N+1. Outputs are held stable until disp_ready_i.
  - Illegal request: done=1, err=1, res=0; the dispatch register is untouched.
- Completion: cmpl_valid_i with a tag whose entry has valid=1 and done=0 sets done=1 and captures err/res. Any other tag is ignored and sets proto_err_o.
- Response (combinational from the head entry):
  - sca_resp_valid_o = table[head].valid & table[head].done.
  - sca_resp_o = {err, res, instr_id} of the head entry; held stable while not taken.
  - On valid&ready: clear the head entry, head++, count--.
  - Response latency: a completion at cycle M for the head slot gives a response at M+1. An illegal request accepted into an empty table at N gives a response at N+1.
- Simultaneous events:
  - Accept + retire in the same cycle: count unchanged.
  - Completion on a non-head slot + retire of head: both take effect.
  - Completion on a slot being retired is impossible (the slot is already done), so it flags proto_err_o.
- busy_o is registered-derived: (count_q != 0) || disp_valid_o.

Decomposition:
- vec_pkg additions:
  - TRANS_ID_BITS (=4, now defined ahead of sca_req_t/sca_resp_t).
  - Opcode localparams OPC_OPV=7'h57, OPC_LOADFP=7'h07, OPC_STOREFP=7'h27.
  - A vec_disp_req_t struct {instr, rs1, rs2, tag}.
- One natural sub-module: vec_sca_rob, the tracking table with alloc/complete/retire ports. The top handles the legality check and the dispatch register.

Test Plan:
- Single legal OP-V (instr=0x0000_0057, id=3), disp_ready_i=1; completion tag 0, res=0x10 two cycles later -> disp_valid_o one cycle after accept with tag 0; response {err=0, res=0x10, id=3} the cycle after completion.
- Illegal instr 0x0000_0033 with id=5 into an empty table -> no disp_valid_o; response {err=1, res=0, id=5} next cycle.
- Ids 1,2,3 dispatched to tags 0,1,2; completions in order tag 2, 0, 1 -> responses in order id 1, 2, 3 with matching res; the id1 response appears one cycle after the tag-0 completion.
- Fill DEPTH=4 entries with no completions and sca_resp_ready_i=0 -> sca_req_ready_o=0 while count_q=4. Complete the head and assert sca_resp_ready_i: that cycle the retire occurs but the 5th request is not accepted; it is accepted the following cycle.
- disp_ready_i held 0 for 5 cycles with a second request pending -> disp outputs stable, sca_req_ready_o=0, second request accepted the cycle disp_ready_i rises.
- Completion to an empty slot (tag 3, table empty) -> proto_err_o=1 sticky, no response. Then rst_i for 1 cycle with 2 entries in flight -> all outputs 0, count_q=0, proto_err_o=0, no stale responses afterwards.

Source files
------------

// File: rtl/vec_sca_responder_pkg.sv
// Shared types and constants for the vector-side scalar-core accelerator responder.
// Contents: XLEN / transaction id widths, legal vector major opcodes, request/response
// structs, the dispatch payload struct, the tracking-table entry struct and an
// opcode legality helper.
package vec_sca_responder_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 4;
    // Widest slot tag the dispatch payload can carry; tables up to 256 entries.
    localparam int unsigned MAX_TAG_BITS  = 8;

    localparam logic [6:0] OPC_OPV     = 7'h57;
    localparam logic [6:0] OPC_LOADFP  = 7'h07;
    localparam logic [6:0] OPC_STOREFP = 7'h27;

    typedef struct packed {
        logic [31:0]              instr;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [TRANS_ID_BITS-1:0] instr_id;
    } sca_req_t;

    typedef struct packed {
        logic                     err;
        logic [XLEN-1:0]          res;
        logic [TRANS_ID_BITS-1:0] instr_id;
    } sca_resp_t;

    typedef struct packed {
        logic [31:0]             instr;
        logic [XLEN-1:0]         rs1;
        logic [XLEN-1:0]         rs2;
        logic [MAX_TAG_BITS-1:0] tag;
    } vec_disp_req_t;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic                     err;
        logic [XLEN-1:0]          res;
        logic [TRANS_ID_BITS-1:0] instr_id;
    } rob_entry_t;

    function automatic logic is_vec_opcode(input logic [6:0] opcode);
        return (opcode == OPC_OPV) || (opcode == OPC_LOADFP) || (opcode == OPC_STOREFP);
    endfunction

endpackage

// File: rtl/vec_sca_responder_if.sv
// Scalar-core accelerator channel: request (valid/ready/payload) and in-order
// response (valid/ready/payload).
//   master : scalar core side (drives requests, takes responses)
//   slave  : vector responder side
interface vec_sca_responder_if;
    import vec_sca_responder_pkg::*;

    logic      sca_req_valid;
    logic      sca_req_ready;
    sca_req_t  sca_req;
    logic      sca_resp_valid;
    logic      sca_resp_ready;
    sca_resp_t sca_resp;

    modport master (
        output sca_req_valid,
        output sca_req,
        output sca_resp_ready,
        input  sca_req_ready,
        input  sca_resp_valid,
        input  sca_resp
    );

    modport slave (
        input  sca_req_valid,
        input  sca_req,
        input  sca_resp_ready,
        output sca_req_ready,
        output sca_resp_valid,
        output sca_resp
    );

endinterface

// File: rtl/vec_sca_rob.sv
// In-order tracking table for outstanding scalar-core requests.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   alloc_i/alloc_illegal_i/alloc_id_i  allocate tail entry; illegal entries are born done+err
//   alloc_tag_o                  slot that an allocation this cycle lands in (tail)
//   count_o                      registered occupancy 0..DEPTH
//   cmpl_*_i                     out-of-order backend completion by slot tag
//   head_valid_o/head_resp_o     head entry is done; its response payload
//   retire_i                     head response taken this cycle
//   proto_err_o                  sticky: completion to an invalid or already-done slot
module vec_sca_rob
    import vec_sca_responder_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_BITS = $clog2(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alloc_i,
    input  logic                         alloc_illegal_i,
    input  logic [TRANS_ID_BITS-1:0]     alloc_id_i,
    output logic [TAG_BITS-1:0]          alloc_tag_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic                         cmpl_valid_i,
    input  logic [TAG_BITS-1:0]          cmpl_tag_i,
    input  logic                         cmpl_err_i,
    input  logic [XLEN-1:0]              cmpl_res_i,
    output logic                         head_valid_o,
    output sca_resp_t                    head_resp_o,
    input  logic                         retire_i,
    output logic                         proto_err_o
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    rob_entry_t          table_q [DEPTH];
    logic [TAG_BITS-1:0] head_q;
    logic [TAG_BITS-1:0] tail_q;
    logic [CNT_BITS-1:0] count_q;
    logic                proto_err_q;
    logic                cmpl_ok;

    // A slot being retired is already done, so a completion aimed at it lands in
    // the protocol-error branch and never races the retire clear.
    assign cmpl_ok = table_q[cmpl_tag_i].valid && !table_q[cmpl_tag_i].done;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (cmpl_valid_i) begin
                if (cmpl_ok) begin
                    table_q[cmpl_tag_i].done <= 1'b1;
                    table_q[cmpl_tag_i].err  <= cmpl_err_i;
                    table_q[cmpl_tag_i].res  <= cmpl_res_i;
                end else begin
                    proto_err_q <= 1'b1;
                end
            end
            if (retire_i) begin
                table_q[head_q] <= '0;
                head_q          <= head_q + TAG_BITS'(1);
            end
            // Allocation only happens when count_q < DEPTH, so tail never aliases
            // a live head being retired.
            if (alloc_i) begin
                table_q[tail_q] <= '{valid:    1'b1,
                                     done:     alloc_illegal_i,
                                     err:      alloc_illegal_i,
                                     res:      '0,
                                     instr_id: alloc_id_i};
                tail_q          <= tail_q + TAG_BITS'(1);
            end
            count_q <= count_q + CNT_BITS'(alloc_i) - CNT_BITS'(retire_i);
        end
    end

    assign alloc_tag_o  = tail_q;
    assign count_o      = count_q;
    assign head_valid_o = table_q[head_q].valid && table_q[head_q].done;
    assign head_resp_o  = '{err:      table_q[head_q].err,
                            res:      table_q[head_q].res,
                            instr_id: table_q[head_q].instr_id};
    assign proto_err_o  = proto_err_q;

endmodule

// File: rtl/vec_sca_responder.sv
// Vector-side responder for the scalar-core accelerator interface. Every accepted
// request gets exactly one response, in request order. Legal vector major opcodes
// are forwarded through a registered dispatch slot tagged with their table slot;
// illegal opcodes are answered with err=1 without dispatch.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   sca                 request/response channel (slave side)
//   disp_*              registered dispatch to vector decode (valid/ready)
//   cmpl_*              backend completion strobe by slot tag, no backpressure
//   busy_o              entries outstanding or dispatch pending
//   proto_err_o         sticky completion protocol error
module vec_sca_responder
    import vec_sca_responder_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_BITS = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vec_sca_responder_if.slave  sca,
    output logic                disp_valid_o,
    input  logic                disp_ready_i,
    output logic [31:0]         disp_instr_o,
    output logic [XLEN-1:0]     disp_rs1_o,
    output logic [XLEN-1:0]     disp_rs2_o,
    output logic [TAG_BITS-1:0] disp_tag_o,
    input  logic                cmpl_valid_i,
    input  logic [TAG_BITS-1:0] cmpl_tag_i,
    input  logic                cmpl_err_i,
    input  logic [XLEN-1:0]     cmpl_res_i,
    output logic                busy_o,
    output logic                proto_err_o
);

    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    logic [CNT_BITS-1:0] count;
    logic [TAG_BITS-1:0] alloc_tag;
    logic                req_legal;
    logic                req_fire;
    logic                resp_fire;
    logic                head_valid;
    sca_resp_t           head_resp;
    vec_disp_req_t       disp_q;
    logic                disp_valid_q;
    logic                unused_tag_hi;

    assign req_legal = is_vec_opcode(sca.sca_req.instr[6:0]);

    // Registered count: a full table stays closed even if the head retires this cycle.
    assign sca.sca_req_ready = (count < CNT_BITS'(DEPTH)) && (!disp_valid_q || disp_ready_i);
    assign req_fire          = sca.sca_req_valid && sca.sca_req_ready;
    assign resp_fire         = head_valid && sca.sca_resp_ready;

    vec_sca_rob #(
        .DEPTH    (DEPTH),
        .TAG_BITS (TAG_BITS)
    ) u_rob (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .alloc_i         (req_fire),
        .alloc_illegal_i (!req_legal),
        .alloc_id_i      (sca.sca_req.instr_id),
        .alloc_tag_o     (alloc_tag),
        .count_o         (count),
        .cmpl_valid_i    (cmpl_valid_i),
        .cmpl_tag_i      (cmpl_tag_i),
        .cmpl_err_i      (cmpl_err_i),
        .cmpl_res_i      (cmpl_res_i),
        .head_valid_o    (head_valid),
        .head_resp_o     (head_resp),
        .retire_i        (resp_fire),
        .proto_err_o     (proto_err_o)
    );

    // Dispatch register: payload is frozen while valid and not consumed. Ready
    // gating above guarantees a new legal accept only when the slot is free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_valid_q <= 1'b0;
            disp_q       <= '0;
        end else if (req_fire && req_legal) begin
            disp_valid_q <= 1'b1;
            disp_q       <= '{instr: sca.sca_req.instr,
                              rs1:   sca.sca_req.rs1,
                              rs2:   sca.sca_req.rs2,
                              tag:   MAX_TAG_BITS'(alloc_tag)};
        end else if (disp_ready_i) begin
            disp_valid_q <= 1'b0;
        end
    end

    assign disp_valid_o = disp_valid_q;
    assign disp_instr_o = disp_q.instr;
    assign disp_rs1_o   = disp_q.rs1;
    assign disp_rs2_o   = disp_q.rs2;
    assign disp_tag_o   = disp_q.tag[TAG_BITS-1:0];
    // Upper tag bits are always zero-extension.
    assign unused_tag_hi = ^disp_q.tag;

    assign sca.sca_resp_valid = head_valid;
    assign sca.sca_resp       = head_resp;

    assign busy_o = (count != '0) || disp_valid_q;

endmodule
